// File: rtl/exp_series_ctrl_if.sv
// Handshake and datapath-control bundle for the series-expansion sequencer.
//   master : top-level/datapath side; drives start, abort, less_cmp and
//            receives every select, load, init and status line.
//   slave  : the sequencer (exp_series_ctrl).
// Signals: start/abort (handshake), less_cmp (term <= threshold flag),
//   s1_rom/s1_x, s2_tmp/s2_x, s3, s4_in/s4_mult (datapath selects),
//   ld_x/ld_y/ld_tmp/ld_ans (loads), init_tmp/init_ans (presets),
//   sub (accumulator subtract), busy, done, n_terms (status).
interface exp_series_ctrl_if;
  localparam int unsigned SEL_W = 3;
  localparam int unsigned CNT_W = 4;

  logic             start;
  logic             abort;
  logic             less_cmp;
  logic             s1_rom;
  logic             s1_x;
  logic             s2_tmp;
  logic             s2_x;
  logic [SEL_W-1:0] s3;
  logic             s4_in;
  logic             s4_mult;
  logic             ld_x;
  logic             ld_y;
  logic             ld_tmp;
  logic             ld_ans;
  logic             init_tmp;
  logic             init_ans;
  logic             sub;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] n_terms;

  modport master (
    output start, abort, less_cmp,
    input  s1_rom, s1_x, s2_tmp, s2_x, s3, s4_in, s4_mult,
           ld_x, ld_y, ld_tmp, ld_ans, init_tmp, init_ans,
           sub, busy, done, n_terms
  );

  modport slave (
    input  start, abort, less_cmp,
    output s1_rom, s1_x, s2_tmp, s2_x, s3, s4_in, s4_mult,
           ld_x, ld_y, ld_tmp, ld_ans, init_tmp, init_ans,
           sub, busy, done, n_terms
  );
endinterface

// File: rtl/exp_series_ctrl.sv
// Sequencer for the Q8.8 series-expansion datapath. Loads x and the
// threshold, presets term/accumulator to 1.0, then iterates up to TERMS
// times: tmp <= x*tmp, tmp <= rom[k]*tmp, compare, accumulate. Exits early
// when the datapath reports the term at or below the threshold.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : exp_series_ctrl_if.slave (handshake, datapath controls, status)
// Every output is a flop; the decode works on the next state so each
// control is valid for exactly the cycle its state occupies.
module exp_series_ctrl #(
  parameter int unsigned TERMS    = 8,
  parameter bit          ALT_SIGN = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  exp_series_ctrl_if.slave   bus
);

  localparam int unsigned SEL_W = 3;
  localparam int unsigned CNT_W = 4;
  localparam logic [SEL_W-1:0] K_LAST = SEL_W'(TERMS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_MULX  = 3'd2,
    S_MULC  = 3'd3,
    S_CHECK = 3'd4,
    S_ACC   = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  typedef struct packed {
    logic             busy;
    logic             done;
    logic             sub;
    logic             ld_ans;
    logic             ld_tmp;
    logic             ld_y;
    logic             ld_x;
    logic             init_ans;
    logic             init_tmp;
    logic             s4_mult;
    logic             s4_in;
    logic [SEL_W-1:0] s3;
    logic             s2_x;
    logic             s2_tmp;
    logic             s1_x;
    logic             s1_rom;
  } ctl_t;

  // Idle/reset value: only the complement selects sit high.
  localparam ctl_t CTL_RST = '{s4_mult: 1'b1, s2_x: 1'b1, s1_x: 1'b1, default: '0};

  state_t           state, state_nxt;
  logic [SEL_W-1:0] k, k_nxt;
  logic [CNT_W-1:0] n_terms_q, n_nxt;
  ctl_t             ctl_q, ctl_nxt;

  // State, term counter, accumulated-term count and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      k         <= '0;
      n_terms_q <= '0;
      ctl_q     <= CTL_RST;
    end else begin
      state     <= state_nxt;
      k         <= k_nxt;
      n_terms_q <= n_nxt;
      ctl_q     <= ctl_nxt;
    end
  end

  // Next state, counters, and decode of the controls for the next cycle.
  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    n_nxt     = n_terms_q;
    ctl_nxt   = CTL_RST;

    case (state)
      S_IDLE: begin
        // Counters clear on acceptance so n_terms survives until a new start.
        if (bus.start && !bus.abort) begin
          state_nxt = S_LOAD;
          k_nxt     = '0;
          n_nxt     = '0;
        end
      end
      S_LOAD:  state_nxt = S_MULX;
      S_MULX:  state_nxt = S_MULC;
      S_MULC:  state_nxt = S_CHECK;
      S_CHECK: state_nxt = bus.less_cmp ? S_DONE : S_ACC;
      S_ACC: begin
        n_nxt = n_terms_q + CNT_W'(1);
        if (k == K_LAST) begin
          state_nxt = S_DONE;
        end else begin
          k_nxt     = k + SEL_W'(1);
          state_nxt = S_MULX;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    // Abort overrides everything and freezes the counters.
    if (state != S_IDLE && bus.abort) begin
      state_nxt = S_IDLE;
      k_nxt     = k;
      n_nxt     = n_terms_q;
    end

    case (state_nxt)
      S_LOAD: begin
        ctl_nxt.ld_x     = 1'b1;
        ctl_nxt.ld_y     = 1'b1;
        ctl_nxt.s4_in    = 1'b1;
        ctl_nxt.init_tmp = 1'b1;
        ctl_nxt.init_ans = 1'b1;
      end
      S_MULX: begin
        ctl_nxt.s1_rom = 1'b0;
        ctl_nxt.s2_tmp = 1'b1;
        ctl_nxt.ld_tmp = 1'b1;
      end
      S_MULC: begin
        ctl_nxt.s1_rom = 1'b1;
        ctl_nxt.s2_tmp = 1'b1;
        ctl_nxt.s3     = k_nxt;
        ctl_nxt.ld_tmp = 1'b1;
      end
      S_ACC: begin
        ctl_nxt.ld_ans = 1'b1;
        // k even <=> odd-numbered (1-based) term.
        ctl_nxt.sub    = ALT_SIGN & ~k_nxt[0];
      end
      S_DONE:  ctl_nxt.done = 1'b1;
      default: ;
    endcase

    ctl_nxt.busy    = (state_nxt != S_IDLE);
    ctl_nxt.s1_x    = ~ctl_nxt.s1_rom;
    ctl_nxt.s2_x    = ~ctl_nxt.s2_tmp;
    ctl_nxt.s4_mult = ~ctl_nxt.s4_in;
  end

  assign bus.s1_rom   = ctl_q.s1_rom;
  assign bus.s1_x     = ctl_q.s1_x;
  assign bus.s2_tmp   = ctl_q.s2_tmp;
  assign bus.s2_x     = ctl_q.s2_x;
  assign bus.s3       = ctl_q.s3;
  assign bus.s4_in    = ctl_q.s4_in;
  assign bus.s4_mult  = ctl_q.s4_mult;
  assign bus.ld_x     = ctl_q.ld_x;
  assign bus.ld_y     = ctl_q.ld_y;
  assign bus.ld_tmp   = ctl_q.ld_tmp;
  assign bus.ld_ans   = ctl_q.ld_ans;
  assign bus.init_tmp = ctl_q.init_tmp;
  assign bus.init_ans = ctl_q.init_ans;
  assign bus.sub      = ctl_q.sub;
  assign bus.busy     = ctl_q.busy;
  assign bus.done     = ctl_q.done;
  assign bus.n_terms  = n_terms_q;

endmodule

// File: tb/tb_exp_series_ctrl.sv
// Bench for exp_series_ctrl: two instances (TERMS=8/ALT_SIGN=0 and
// TERMS=4/ALT_SIGN=1) share stimulus; each cycle both are compared with a
// schedule model that derives the phase of a run from cycle arithmetic.
module tb_exp_series_ctrl;

  localparam int M_IDLE  = 0;
  localparam int M_LOAD  = 1;
  localparam int M_MULX  = 2;
  localparam int M_MULC  = 3;
  localparam int M_CHECK = 4;
  localparam int M_ACC   = 5;
  localparam int M_DONE  = 6;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  exp_series_ctrl_if bus0 ();
  exp_series_ctrl_if bus1 ();

  exp_series_ctrl #(.TERMS(8), .ALT_SIGN(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  exp_series_ctrl #(.TERMS(4), .ALT_SIGN(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  logic [17:0] obs0, obs1;
  assign obs0 = {bus0.busy, bus0.done, bus0.sub, bus0.ld_ans, bus0.ld_tmp, bus0.ld_y,
                 bus0.ld_x, bus0.init_ans, bus0.init_tmp, bus0.s4_mult, bus0.s4_in,
                 bus0.s3, bus0.s2_x, bus0.s2_tmp, bus0.s1_x, bus0.s1_rom};
  assign obs1 = {bus1.busy, bus1.done, bus1.sub, bus1.ld_ans, bus1.ld_tmp, bus1.ld_y,
                 bus1.ld_x, bus1.init_ans, bus1.init_tmp, bus1.s4_mult, bus1.s4_in,
                 bus1.s3, bus1.s2_x, bus1.s2_tmp, bus1.s1_x, bus1.s1_rom};

  // Cycle (counted after E0) in which DONE appears for an unaborted run.
  function automatic int end_cycle(input int terms, input int sn);
    return (sn >= 1 && sn <= terms) ? 4 * sn : 4 * terms + 1;
  endfunction

  function automatic int eff_end(input int terms, input int sn, input int ab);
    int e;
    e = end_cycle(terms, sn);
    if (ab >= 0 && ab < e) e = ab;
    return e;
  endfunction

  // sn: term whose CHECK sees less_cmp=1 (0 = never); ab: abort cycle (-1 = none).
  function automatic void model(input int c, input int terms, input int sn, input int ab,
                                output int st, output int k, output int n);
    int e;
    bit aborted;
    e       = end_cycle(terms, sn);
    aborted = (ab >= 0 && ab < e);
    st = M_IDLE;
    k  = 0;
    n  = 0;
    for (int t = 1; t <= terms; t++)
      if ((sn == 0 || t < sn) && 4 * t < c && (!aborted || 4 * t < ab)) n++;
    if (aborted && c > ab) st = M_IDLE;
    else if (c == 0) st = M_LOAD;
    else if (c < e) begin
      k = (c - 1) / 4;
      case ((c - 1) % 4)
        0:       st = M_MULX;
        1:       st = M_MULC;
        2:       st = M_CHECK;
        default: st = M_ACC;
      endcase
    end else if (c == e) st = M_DONE;
  endfunction

  function automatic logic [17:0] exp_vec(input int st, input int k, input bit alt);
    logic s1_rom, s2_tmp, s4_in, ld_x, ld_y, ld_tmp, ld_ans, init_t, init_a, sub, done, busy;
    logic [2:0] s3;
    s1_rom = (st == M_MULC);
    s2_tmp = (st == M_MULX) || (st == M_MULC);
    s3     = (st == M_MULC) ? 3'(k) : 3'd0;
    s4_in  = (st == M_LOAD);
    ld_x   = (st == M_LOAD);
    ld_y   = (st == M_LOAD);
    init_t = (st == M_LOAD);
    init_a = (st == M_LOAD);
    ld_tmp = s2_tmp;
    ld_ans = (st == M_ACC);
    sub    = (st == M_ACC) && alt && (k % 2 == 0);
    done   = (st == M_DONE);
    busy   = (st != M_IDLE);
    return {busy, done, sub, ld_ans, ld_tmp, ld_y, ld_x, init_a, init_t, ~s4_in, s4_in,
            s3, ~s2_tmp, s2_tmp, ~s1_rom, s1_rom};
  endfunction

  task automatic check(input string tag, input int c, input logic [31:0] o, input logic [31:0] e);
    tests++;
    assert (o === e)
    else begin
      fails++;
      $error("FAIL %s cycle=%0d got=%h expected=%h", tag, c, o, e);
    end
  endtask

  task automatic drive(input logic l, input logic a, input logic s);
    bus0.less_cmp = l; bus1.less_cmp = l;
    bus0.abort    = a; bus1.abort    = a;
    bus0.start    = s; bus1.start    = s;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_outs0"}, -1, 32'(obs0), 32'(exp_vec(M_IDLE, 0, 1'b0)));
    check({tag, "_outs1"}, -1, 32'(obs1), 32'(exp_vec(M_IDLE, 0, 1'b1)));
    check({tag, "_n0"},    -1, 32'(bus0.n_terms), 32'd0);
    check({tag, "_n1"},    -1, 32'(bus1.n_terms), 32'd0);
  endtask

  // Present start for one edge (E0); returns #1 after E0.
  task automatic kick();
    drive(1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
  endtask

  // Entered #1 after E0. chain: start again in the first cycle where both are idle.
  // cut: return just after driving cycle `cut` (-1 = run to the end).
  task automatic run(input int sn, input int ab, input int sp, input bit chain, input int cut);
    int e0, e1, last, st, k, n;
    e0   = eff_end(8, sn, ab);
    e1   = eff_end(4, sn, ab);
    last = ((e0 > e1) ? e0 : e1) + 1;
    for (int c = 0; c <= last; c++) begin
      drive(c == 4 * sn - 1, c == ab, (chain && c == last) || c == sp);
      if (c == cut) return;
      @(negedge clk);
      model(c, 8, sn, ab, st, k, n);
      check("dut0_outs", c, 32'(obs0), 32'(exp_vec(st, k, 1'b0)));
      check("dut0_nterms", c, 32'(bus0.n_terms), 32'(n));
      model(c, 4, sn, ab, st, k, n);
      check("dut1_outs", c, 32'(obs1), 32'(exp_vec(st, k, 1'b1)));
      check("dut1_nterms", c, 32'(bus1.n_terms), 32'(n));
      @(posedge clk); #1;
    end
    drive(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int sn, ab, sp, mn;
    bit ch;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    #3;
    check_idle("reset");
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Early stop after two accumulated terms (DONE after E12).
    kick(); run(3, -1, -1, 1'b0, -1);
    // Immediate stop: first CHECK already below threshold (DONE after E4).
    kick(); run(1, -1, -1, 1'b0, -1);
    // Full run: TERMS=4 instance ends after E17, TERMS=8 after E33.
    kick(); run(0, -1, -1, 1'b0, -1);
    // Abort in MULC of term 2.
    kick(); run(0, 6, -1, 1'b0, -1);
    // Spurious start while busy, then restart in the first idle cycle.
    kick(); run(3, -1, 5, 1'b1, -1);
    run(1, -1, -1, 1'b0, -1);

    // Asynchronous reset in CHECK of term 1.
    kick(); run(3, -1, -1, 1'b0, 3);
    #1 rst = 1'b1;
    #1 check_idle("rst_async");
    @(posedge clk); #1 check_idle("rst_held");
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1 check_idle("rst_release");
    kick(); run(3, -1, -1, 1'b0, -1);

    // Randomized runs.
    ch = 1'b0;
    for (int i = 0; i < 16; i++) begin
      sn = int'($urandom_range(0, 9));
      mn = (end_cycle(8, sn) < end_cycle(4, sn)) ? end_cycle(8, sn) : end_cycle(4, sn);
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, mn)) : -1;
      if (ab >= 0 && ab < mn) mn = ab;
      sp = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, mn)) : -1;
      if (!ch) kick();
      ch = (i != 15) && ($urandom_range(0, 1) == 1);
      run(sn, ab, sp, ch, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
